// File: rtl/facto_pkg.sv
// Shared constants for the queued factorial accelerator: register offsets,
// FSM state encodings and STATUS bit positions.
package facto_pkg;

  localparam logic [7:0] OFF_OPSTART  = 8'h00;
  localparam logic [7:0] OFF_OPCLEAR  = 8'h08;
  localparam logic [7:0] OFF_STATUS   = 8'h10;
  localparam logic [7:0] OFF_INTREN   = 8'h18;
  localparam logic [7:0] OFF_OPERAND  = 8'h20;
  localparam logic [7:0] OFF_RESULT_H = 8'h28;
  localparam logic [7:0] OFF_RESULT_L = 8'h30;
  localparam logic [7:0] OFF_PERF     = 8'h38;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_POP   = 3'd1;
  localparam state_t S_CHECK = 3'd2;
  localparam state_t S_MUL   = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  localparam int ST_DONE     = 0;
  localparam int ST_BUSY     = 1;
  localparam int ST_OVF      = 2;
  localparam int ST_FULL     = 3;
  localparam int ST_EMPTY    = 4;
  localparam int ST_PUSH_ERR = 5;
  localparam int ST_COUNT    = 8;

endpackage

// File: rtl/facto_mul.sv
// Iterative multiplier: p = a * b, retiring MUL_BITS of b per cycle.
// The first slice is taken on the start cycle; done pulses once all slices are summed.
module facto_mul #(
  parameter int DATA_W   = 64,
  parameter int MUL_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2*DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   p,
  output logic                  ovf
);

  localparam int STEPS = DATA_W / MUL_BITS;
  localparam int FW    = 3 * DATA_W;
  localparam int CW    = $clog2(STEPS + 1);

  logic [FW-1:0]       prod;
  logic [FW-1:0]       a_sh;
  logic [DATA_W-1:0]   b_sh;
  logic [CW-1:0]       cnt;
  logic                running;
  logic [FW-1:0]       op_a;
  logic [MUL_BITS-1:0] op_b;
  logic [FW-1:0]       step_term;

  always_comb begin
    op_a      = start ? FW'(a) : a_sh;
    op_b      = start ? b[MUL_BITS-1:0] : b_sh[MUL_BITS-1:0];
    step_term = op_a * FW'(op_b);
  end

  // The full-width accumulator keeps the bits above 2*DATA_W so overflow can be reported.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod    <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        prod    <= step_term;
        a_sh    <= FW'(a) << MUL_BITS;
        b_sh    <= b >> MUL_BITS;
        cnt     <= CW'(1);
        running <= (STEPS > 1);
        done    <= (STEPS == 1);
      end else if (running) begin
        prod <= prod + step_term;
        a_sh <= a_sh << MUL_BITS;
        b_sh <= b_sh >> MUL_BITS;
        cnt  <= cnt + 1'b1;
        if (cnt == CW'(STEPS - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign p   = prod[2*DATA_W-1:0];
  assign ovf = |prod[FW-1:2*DATA_W];

endmodule

// File: rtl/facto_core_q.sv
// Queued factorial accelerator bus slave: operand FIFO, job FSM and result registers.
// Optional FACTO_PERF_CNT_EN adds a per-job cycle counter readable at offset 0x38.
module facto_core_q
  import facto_pkg::*;
#(
  parameter int          DATA_W     = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MUL_BITS   = 8,
  parameter logic [15:0] BASE_ADDR  = 16'h7000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [15:0]       s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              interrupt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  state_t              state;
  logic [2*DATA_W-1:0] acc, result, mul_p;
  logic [DATA_W-1:0]   k, perf_dat;
  logic                done, ovf, push_err, intr_en;
  logic                done_nxt, intr_nxt, mul_done, mul_ovf;

  logic [7:0] off;
  logic page_hit, wr_en, do_start, do_clear, do_ack, do_intr, do_push;
  logic fifo_full, fifo_empty, push_ok, pop, k_le1, mul_start;

  assign off        = s_addr[7:0];
  assign page_hit   = (s_addr[15:8] == BASE_ADDR[15:8]);
  assign wr_en      = s_sel & s_wr & page_hit;
  assign do_start   = wr_en & (off == OFF_OPSTART) & s_din[0];
  assign do_clear   = wr_en & (off == OFF_OPCLEAR) & s_din[0];
  assign do_ack     = wr_en & (off == OFF_STATUS)  & s_din[0];
  assign do_intr    = wr_en & (off == OFF_INTREN);
  assign do_push    = wr_en & (off == OFF_OPERAND);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push_ok    = do_push & ~fifo_full;
  assign pop        = (state == S_POP);
  assign k_le1      = (k <= DATA_W'(1));
  assign mul_start  = (state == S_CHECK) & ~k_le1;

  facto_mul #(.DATA_W(DATA_W), .MUL_BITS(MUL_BITS)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (acc),
    .b     (k),
    .done  (mul_done),
    .p     (mul_p),
    .ovf   (mul_ovf)
  );

  // Next values feed both the flags and the registered interrupt so they stay aligned.
  always_comb begin
    done_nxt = done;
    if (do_clear)
      done_nxt = 1'b0;
    else if ((state == S_DONE) && do_ack)
      done_nxt = 1'b0;
    else if ((state == S_CHECK) && k_le1)
      done_nxt = 1'b1;
    intr_nxt = do_intr ? s_din[0] : intr_en;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= s_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      acc       <= '0;
      k         <= '0;
      result    <= '0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      push_err  <= 1'b0;
      intr_en   <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      done      <= done_nxt;
      intr_en   <= intr_nxt;
      interrupt <= done_nxt & intr_nxt;
      if (do_clear) begin
        state    <= S_IDLE;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        result   <= '0;
        ovf      <= 1'b0;
        push_err <= 1'b0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + PW'(1);
        if (do_push && fifo_full)
          push_err <= 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push_ok) - CW'(pop);
        case (state)
          S_IDLE:  if (do_start && !fifo_empty) state <= S_POP;
          S_POP: begin
            acc   <= (2*DATA_W)'(1);
            k     <= fifo_mem[rd_ptr];
            ovf   <= 1'b0;
            state <= S_CHECK;
          end
          S_CHECK: begin
            if (k_le1) begin
              result <= acc;
              state  <= S_DONE;
            end else begin
              state <= S_MUL;
            end
          end
          S_MUL: begin
            if (mul_done) begin
              acc   <= mul_p;
              k     <= k - DATA_W'(1);
              ovf   <= ovf | mul_ovf;
              state <= S_CHECK;
            end
          end
          S_DONE:  if (do_ack) state <= fifo_empty ? S_IDLE : S_POP;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef FACTO_PERF_CNT_EN
  logic [31:0] perf_run, perf_lat;

  // Counts cycles spent in CHECK/MUL for the current job; snapshot taken on DONE entry.
  always_ff @(posedge clk) begin
    if (reset || do_clear) begin
      perf_run <= '0;
      perf_lat <= '0;
    end else begin
      if (pop)
        perf_run <= '0;
      else if ((state == S_CHECK) || (state == S_MUL))
        perf_run <= perf_run + 32'd1;
      if ((state == S_CHECK) && k_le1)
        perf_lat <= perf_run;
    end
  end

  assign perf_dat = DATA_W'(perf_lat);
`else
  assign perf_dat = '0;
`endif

  always_comb begin
    s_dout = '0;
    if (s_sel && !s_wr && page_hit) begin
      case (off)
        OFF_STATUS: begin
          s_dout[ST_DONE]        = done;
          s_dout[ST_BUSY]        = (state != S_IDLE);
          s_dout[ST_OVF]         = ovf;
          s_dout[ST_FULL]        = fifo_full;
          s_dout[ST_EMPTY]       = fifo_empty;
          s_dout[ST_PUSH_ERR]    = push_err;
          s_dout[ST_COUNT +: 8]  = 8'(count);
        end
        OFF_INTREN:   s_dout[0] = intr_en;
        OFF_OPERAND:  s_dout    = DATA_W'(count);
        OFF_RESULT_H: s_dout    = result[2*DATA_W-1:DATA_W];
        OFF_RESULT_L: s_dout    = result[DATA_W-1:0];
        OFF_PERF:     s_dout    = perf_dat;
        default:      s_dout    = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_facto_core_q.sv
// Scoreboard bench for facto_core_q: expected factorials are queued on push
// and compared when the core reports done.
module tb_facto_core_q;

  localparam logic [15:0] BASE      = 16'h7000;
  localparam logic [7:0]  A_START   = 8'h00;
  localparam logic [7:0]  A_CLEAR   = 8'h08;
  localparam logic [7:0]  A_STATUS  = 8'h10;
  localparam logic [7:0]  A_INTREN  = 8'h18;
  localparam logic [7:0]  A_OPERAND = 8'h20;
  localparam logic [7:0]  A_RES_H   = 8'h28;
  localparam logic [7:0]  A_RES_L   = 8'h30;
  localparam logic [7:0]  A_PERF    = 8'h38;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_sel = 1'b0;
  logic        s_wr = 1'b0;
  logic [15:0] s_addr = '0;
  logic [63:0] s_din = '0;
  logic [63:0] s_dout;
  logic        interrupt;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_res_q[$];
  logic         exp_ovf_q[$];

  always #5 clk = ~clk;

  facto_core_q dut (
    .clk       (clk),
    .reset     (reset),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .interrupt (interrupt)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  // Descending multiplication with 128-bit truncation and overflow tracking.
  function automatic void model(input logic [63:0] n, output logic [127:0] r, output logic o);
    logic [191:0] full;
    r = 128'd1;
    o = 1'b0;
    for (logic [63:0] kk = n; kk > 64'd1; kk--) begin
      full = {64'd0, r} * {128'd0, kk};
      o    = o | (|full[191:128]);
      r    = full[127:0];
    end
  endfunction

  task automatic bus_write(input logic [7:0] off, input logic [63:0] d);
    @(negedge clk);
    s_sel  = 1'b1;
    s_wr   = 1'b1;
    s_addr = {BASE[15:8], off};
    s_din  = d;
    @(negedge clk);
    s_sel  = 1'b0;
    s_wr   = 1'b0;
    s_din  = '0;
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [63:0] d);
    @(negedge clk);
    s_sel  = 1'b1;
    s_wr   = 1'b0;
    s_addr = {BASE[15:8], off};
    #1;
    d      = s_dout;
    s_sel  = 1'b0;
  endtask

  task automatic push_op(input logic [63:0] v, input bit kept);
    logic [127:0] r;
    logic o;
    bus_write(A_OPERAND, v);
    if (kept) begin
      model(v, r, o);
      exp_res_q.push_back(r);
      exp_ovf_q.push_back(o);
    end
  endtask

  task automatic wait_done();
    logic [63:0] d;
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      bus_read(A_STATUS, d);
      seen = d[0];
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL done_timeout got 0 want 1");
    end
  endtask

  task automatic check_next_result();
    logic [63:0]  hi, lo, d;
    logic [127:0] exp;
    logic         eo;
    wait_done();
    checks++;
    if (exp_res_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty got done want no result");
      return;
    end
    exp = exp_res_q.pop_front();
    eo  = exp_ovf_q.pop_front();
    bus_read(A_RES_H, hi);
    bus_read(A_RES_L, lo);
    bus_read(A_STATUS, d);
    if ({hi, lo} !== exp) begin
      errors++;
      $display("[TB] FAIL result got %0h want %0h", {hi, lo}, exp);
    end
    checks++;
    if (d[2] !== eo) begin
      errors++;
      $display("[TB] FAIL ovf got %0b want %0b", d[2], eo);
    end
    checks++;
    if (interrupt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL interrupt_on_done got %0b want 1", interrupt);
    end
    bus_write(A_STATUS, 64'd1);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL interrupt_after_ack got %0b want 0", interrupt);
    end
  endtask

  task automatic test_reset();
    logic [63:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 64'h10) begin
      errors++;
      $display("[TB] FAIL reset_status got %0h want 10", d);
    end
    bus_read(A_RES_L, d);
    checks++;
    if (d !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_result got %0h want 0", d);
    end
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_interrupt got %0b want 0", interrupt);
    end
  endtask

  task automatic test_single();
    logic [63:0] d, exp_perf;
    bit early = 1'b0;
    push_op(64'd5, 1'b1);
    bus_write(A_INTREN, 64'd1);
    bus_write(A_START, 64'd1);
    s_sel  = 1'b1;
    s_wr   = 1'b0;
    s_addr = {BASE[15:8], A_STATUS};
    for (int i = 1; i < 38; i++) begin
      @(posedge clk);
      #1;
      if (s_dout[0]) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("[TB] FAIL latency_early got done before 38 want after");
    end
    @(posedge clk);
    #1;
    checks++;
    if (s_dout[0] !== 1'b1 || interrupt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_38 got done=%0b int=%0b want 1 1", s_dout[0], interrupt);
    end
    s_sel = 1'b0;
    bus_read(A_RES_L, d);
    checks++;
    if (d !== 64'd120) begin
      errors++;
      $display("[TB] FAIL fact5 got %0d want 120", d);
    end
`ifdef FACTO_PERF_CNT_EN
    exp_perf = 64'd36;
`else
    exp_perf = 64'd0;
`endif
    bus_read(A_PERF, d);
    checks++;
    if (d !== exp_perf) begin
      errors++;
      $display("[TB] FAIL perf got %0d want %0d", d, exp_perf);
    end
    check_next_result();
  endtask

  task automatic test_queue();
    logic [63:0] d;
    push_op(64'd0, 1'b1);
    push_op(64'd1, 1'b1);
    push_op(64'd10, 1'b1);
    bus_write(A_START, 64'd1);
    repeat (3) check_next_result();
    bus_read(A_STATUS, d);
    checks++;
    if (d[4] !== 1'b1 || d[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL queue_drained got empty=%0b busy=%0b want 1 0", d[4], d[1]);
    end
  endtask

  task automatic test_big();
    logic [63:0] hi, lo, d;
    push_op(64'd21, 1'b1);
    bus_write(A_START, 64'd1);
    wait_done();
    bus_read(A_RES_H, hi);
    bus_read(A_RES_L, lo);
    checks++;
    if (hi !== 64'd2 || lo !== 64'd14197454024290336768) begin
      errors++;
      $display("[TB] FAIL fact21 got %0d:%0d want 2:14197454024290336768", hi, lo);
    end
    check_next_result();
    push_op(64'd40, 1'b1);
    bus_write(A_START, 64'd1);
    wait_done();
    bus_read(A_STATUS, d);
    checks++;
    if (d[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fact40_ovf got %0b want 1", d[2]);
    end
    check_next_result();
  endtask

  task automatic test_full();
    logic [63:0] d;
    for (int i = 1; i <= 4; i++) push_op(64'(i), 1'b1);
    push_op(64'd5, 1'b0);
    bus_read(A_STATUS, d);
    checks++;
    if (d[15:8] !== 8'd4 || d[3] !== 1'b1 || d[5] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full got cnt=%0d full=%0b perr=%0b want 4 1 1", d[15:8], d[3], d[5]);
    end
    bus_read(A_OPERAND, d);
    checks++;
    if (d !== 64'd4) begin
      errors++;
      $display("[TB] FAIL operand_count got %0d want 4", d);
    end
    bus_write(A_START, 64'd1);
    repeat (4) check_next_result();
    bus_read(A_STATUS, d);
    checks++;
    if (d[1] !== 1'b0 || d[4] !== 1'b1 || d[5] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fifth_lost got busy=%0b empty=%0b perr=%0b want 0 1 1", d[1], d[4], d[5]);
    end
    bus_write(A_CLEAR, 64'd1);
    bus_read(A_STATUS, d);
    checks++;
    if (d[5] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL push_err_clear got %0b want 0", d[5]);
    end
  endtask

  task automatic test_push_during();
    push_op(64'd3, 1'b1);
    bus_write(A_START, 64'd1);
    repeat (5) @(negedge clk);
    push_op(64'd4, 1'b1);
    check_next_result();
    check_next_result();
  endtask

  task automatic test_clear();
    logic [63:0] d, hi, lo;
    push_op(64'd10, 1'b0);
    push_op(64'd3, 1'b0);
    bus_write(A_START, 64'd1);
    repeat (20) @(posedge clk);
    bus_write(A_CLEAR, 64'd1);
    bus_read(A_STATUS, d);
    checks++;
    if (d[1] !== 1'b0 || d[15:8] !== 8'd0) begin
      errors++;
      $display("[TB] FAIL clear_state got busy=%0b cnt=%0d want 0 0", d[1], d[15:8]);
    end
    bus_read(A_RES_H, hi);
    bus_read(A_RES_L, lo);
    checks++;
    if (hi !== 64'd0 || lo !== 64'd0) begin
      errors++;
      $display("[TB] FAIL clear_result got %0h:%0h want 0:0", hi, lo);
    end
    bus_read(A_INTREN, d);
    checks++;
    if (d !== 64'd1) begin
      errors++;
      $display("[TB] FAIL clear_intren got %0d want 1", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    push_op(64'd6, 1'b0);
    bus_write(A_START, 64'd1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 64'h10 || interrupt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid got status=%0h int=%0b want 10 0", d, interrupt);
    end
    bus_read(A_INTREN, d);
    checks++;
    if (d !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_intren got %0d want 0", d);
    end
    push_op(64'd3, 1'b1);
    bus_write(A_INTREN, 64'd1);
    bus_write(A_START, 64'd1);
    check_next_result();
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_big();
    test_full();
    test_push_during();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/facto_core_q.md
Name: facto_core_q

Overview:
Queued factorial accelerator and the successor to the single-shot factorial core. It sits as a bus slave on the 16-bit-address, 64-bit-data slave bus.
- Software pushes up to FIFO_DEPTH operands, then starts the core.
- The core computes each N! in turn using an iterative multi-cycle multiplier.
- After each result it raises done/interrupt and waits for a software acknowledge before starting the next job.

Parameters:
DATA_W, 64, operand and bus word width; result width is 2*DATA_W.
FIFO_DEPTH, 4, operand queue depth; power of two, at least 2.
MUL_BITS, 8, multiplier bits retired per cycle; must divide DATA_W.
BASE_ADDR, 16'h7000, register block base; s_addr[15:8] is compared with BASE_ADDR[15:8].

Ports:
clk  in  1  clock, all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
s_sel  in  1  slave select.
s_wr  in  1  1 = write, 0 = read.
s_addr  in  16  byte address.
s_din  in  DATA_W  write data.
s_dout  out  DATA_W  read data.
interrupt  out  1  registered, equals intr_en & done.

Behaviour:
- Register offsets (on s_addr[7:0]):
  - 0x00 OPSTART: W, bit0 = 1 starts queue processing.
  - 0x08 OPCLEAR: W, bit0 = 1 aborts the job and flushes the queue.
  - 0x10 STATUS: R bits are done[0], busy[1], ovf[2], full[3], empty[4], push_err[5], count[15:8]. W bit0 = 1 is the done acknowledge.
  - 0x18 INTREN: R/W, bit0.
  - 0x20 OPERAND: W pushes s_din into the FIFO; R returns the FIFO count.
  - 0x28 RESULT_H: R.
  - 0x30 RESULT_L: R.
- Writes take effect at the clk edge when s_sel & s_wr and the page matches.
- s_dout is combinational for s_sel & ~s_wr with page match. It is 0 otherwise and for unmapped offsets.
- Reset values: all registers, FIFO pointers, flags, result, s_dout and interrupt are 0. FSM goes to IDLE.
- FSM states:
  - IDLE: wait for OPSTART. OPSTART with an empty FIFO is ignored.
  - POP: load acc = 1 and k = operand; FIFO pops.
  - CHECK: if k <= 1 go to DONE; else start the multiply.
  - MUL: runs DATA_W/MUL_BITS cycles computing acc * k, then k = k - 1 and go back to CHECK.
  - DONE: done = 1; wait for the acknowledge.
- Acknowledge in DONE: clears done. Go to POP if the FIFO is not empty, else IDLE.
- busy = (state != IDLE).
- Latency with DATA_W = 64 and MUL_BITS = 8: done rises 2 + 9*(N-1) cycles after the OPSTART edge for N >= 2, and 2 cycles after it for N <= 1.
- Arithmetic: product is truncated to 2*DATA_W bits. ovf is set if any discarded bit is nonzero. ovf is sticky per job and cleared on POP.
- The result registers update only on entry to DONE and hold until the next DONE or OPCLEAR.
- Boundaries:
  - Push when full: dropped; push_err is set and is cleared only by OPCLEAR.
  - Push during processing: allowed; the operand joins the queue.
  - Push and pop in the same cycle: both happen, count unchanged.
  - OPSTART while busy: ignored.
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - OPCLEAR in any state: state goes to IDLE next cycle; FIFO, result, done, ovf and push_err are cleared; intr_en is kept.
  - OPCLEAR and a push in the same cycle: OPCLEAR wins.
  - Acknowledge outside DONE: ignored.
  - reset has priority over everything, including mid-operation.

Optional Feature:
FACTO_PERF_CNT_EN:
- When defined: adds a 32-bit cycle counter that runs from POP to DONE entry and is latched at DONE. It is readable at 0x38 (zero-extended) and cleared by OPCLEAR/reset.
- When undefined: no counter logic; 0x38 reads 0.

Decomposition:
- Package facto_pkg holds the register offset constants, the FSM state enum and the status bit positions.
- One sub-module, facto_mul: iterative multiplier.
  - Inputs: start, a[2*DATA_W], b[DATA_W].
  - Outputs: done pulse, p[2*DATA_W], ovf.
  - Latency: DATA_W/MUL_BITS cycles.
- The FIFO is inline.

Test Plan:
- Push 5, set INTREN = 1, OPSTART -> 38 cycles later done = 1 and interrupt = 1; RESULT_L = 120, RESULT_H = 0, ovf = 0.
- Push 0, 1, 10, OPSTART, acknowledge each result -> results are 1, 1, 3628800 in order; empty = 1 and busy = 0 after the last acknowledge.
- Push 21 -> RESULT_H = 2, RESULT_L = 14197454024290336768, ovf = 0. Then push 40 -> ovf = 1.
- Push 5 operands with FIFO_DEPTH = 4 -> count = 4, full = 1, push_err = 1, fifth operand lost.
- Push 10 and 3, OPSTART, then OPCLEAR 20 cycles in -> next cycle busy = 0, count = 0, RESULT_H/RESULT_L = 0, intr_en unchanged.
- Drive reset = 1 mid-MUL for one cycle -> all outputs 0 and state IDLE. With FACTO_PERF_CNT_EN, 5! reads 36 at 0x38.
